// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and sizing helpers for the systolic activation feeder.
package tpu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feeder_state_t;

  function automatic int skew_len(int n, int k);
    return k + n - 1;
  endfunction

  // Step counter must hold 0..K+N-1; never narrower than one bit.
  function automatic int cnt_width(int n, int k);
    int w;
    w = $clog2(n + k);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(2, 2);

endpackage

// File: rtl/systolic_skew_feeder_lane_sel.sv
// Per-lane element select: lane LANE shows element (cnt - LANE) when inside its window.
module skew_lane_sel
  import tpu_pkg::*;
#(
  parameter int LANE   = 0,
  parameter int K      = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic [K*DATA_W-1:0] elems,
  input  logic [CNT_W-1:0]    cnt,
  output logic [DATA_W-1:0]   elem,
  output logic                valid
);

  always_comb begin
    elem  = '0;
    valid = 1'b0;
    for (int k = 0; k < K; k++) begin
      if (int'(cnt) == LANE + k) begin
        elem  = elems[k*DATA_W +: DATA_W];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Accepts an N x K activation tile and streams it out diagonally skewed, one lane per array row.
// state  | meaning
// IDLE   | no tile held, outputs zero, ready for a tile
// STREAM | stepping cnt through 0..S-1, ready again only on the last step
module systolic_skew_feeder
  import tpu_pkg::*;
#(
  parameter int N      = 2,
  parameter int K      = 2,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*K*DATA_W-1:0] a_tile,
  output logic [N*DATA_W-1:0]   a_out,
  output logic [N-1:0]          lane_valid,
  output logic                  busy,
  output logic                  tile_done
);

  localparam int S     = skew_len(N, K);
  localparam int LAST  = S - 1;
  localparam int CNT_W = cnt_width(N, K);

  feeder_state_t         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N*K*DATA_W-1:0] tile_q, tile_d;
  logic                  at_last, accept, active_d;
  logic [DATA_W-1:0]     lane_elem [N];
  logic [N-1:0]          lane_vld;

  assign at_last  = (state_q == STREAM) && (cnt_q == CNT_W'(LAST));
  assign in_ready = !reset && ((state_q == IDLE) || at_last);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
    if (accept) begin
      state_d = STREAM;
      cnt_d   = '0;
      tile_d  = a_tile;
    end else if (state_q == STREAM) begin
      if (at_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign active_d = (state_d == STREAM);

  // Lanes look at the next step so outputs can be registered with no extra latency.
  for (genvar r = 0; r < N; r++) begin : g_lane
    skew_lane_sel #(
      .LANE  (r),
      .K     (K),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
    ) u_sel (
      .elems(tile_d[r*K*DATA_W +: K*DATA_W]),
      .cnt  (cnt_d),
      .elem (lane_elem[r]),
      .valid(lane_vld[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tile_q     <= '0;
      a_out      <= '0;
      lane_valid <= '0;
      busy       <= 1'b0;
      tile_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      for (int r = 0; r < N; r++) begin
        a_out[r*DATA_W +: DATA_W] <= active_d ? lane_elem[r] : '0;
      end
      lane_valid <= active_d ? lane_vld : '0;
      busy       <= active_d;
      tile_done  <= active_d && (cnt_d == CNT_W'(LAST));
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench: N=2,K=2 vector table plus hand sequences, and an N=4,K=3 skew check.
module tb_systolic_skew_feeder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // N=2, K=2 instance
  logic        v2, r2, busy2, done2;
  logic [31:0] tile2;
  logic [15:0] out2;
  logic [1:0]  lv2;

  // N=4, K=3 instance
  logic        v4, r4, busy4, done4;
  logic [95:0] tile4;
  logic [31:0] out4;
  logic [3:0]  lv4;

  systolic_skew_feeder #(.N(2), .K(2), .DATA_W(8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(r2), .a_tile(tile2),
    .a_out(out2), .lane_valid(lv2), .busy(busy2), .tile_done(done2)
  );

  systolic_skew_feeder #(.N(4), .K(3), .DATA_W(8)) dut4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4), .a_tile(tile4),
    .a_out(out4), .lane_valid(lv4), .busy(busy4), .tile_done(done4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        in_valid;
    logic [31:0] a_tile;
    logic        exp_ready;
    logic [15:0] exp_out;
    logic [1:0]  exp_lv;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  localparam logic [31:0] TA = 32'h04030201;  // [1,2;3,4]
  localparam logic [31:0] TB = 32'h08070605;  // [5,6;7,8]
  localparam logic [31:0] TC = 32'h0D0C0B0A;  // offered early, must be ignored
  localparam logic [31:0] TD = 32'h14131211;  // applied on the accepting edge

  vec_t vecs[19];

  initial begin
    logic [7:0] e8;

    // single accept
    vecs[0]  = '{1'b1, TA, 1'b1, 16'h0001, 2'b01, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, TA, 1'b0, 16'h0302, 2'b11, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, TA, 1'b0, 16'h0400, 2'b10, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, TA, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, TA, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b0};
    // back-to-back, in_valid held
    vecs[5]  = '{1'b1, TA, 1'b1, 16'h0001, 2'b01, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, TB, 1'b0, 16'h0302, 2'b11, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, TB, 1'b0, 16'h0400, 2'b10, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, TB, 1'b1, 16'h0005, 2'b01, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, TB, 1'b0, 16'h0706, 2'b11, 1'b1, 1'b0};
    vecs[10] = '{1'b0, TB, 1'b0, 16'h0800, 2'b10, 1'b1, 1'b1};
    vecs[11] = '{1'b0, TB, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b0};
    // backpressure: new tile offered from step 0, swapped before the accepting edge
    vecs[12] = '{1'b1, TA, 1'b1, 16'h0001, 2'b01, 1'b1, 1'b0};
    vecs[13] = '{1'b1, TC, 1'b0, 16'h0302, 2'b11, 1'b1, 1'b0};
    vecs[14] = '{1'b1, TC, 1'b0, 16'h0400, 2'b10, 1'b1, 1'b1};
    vecs[15] = '{1'b1, TD, 1'b1, 16'h0011, 2'b01, 1'b1, 1'b0};
    vecs[16] = '{1'b0, TD, 1'b0, 16'h1312, 2'b11, 1'b1, 1'b0};
    vecs[17] = '{1'b0, TD, 1'b0, 16'h1400, 2'b10, 1'b1, 1'b1};
    vecs[18] = '{1'b0, TD, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b0};

    reset = 1'b1;
    v2 = 1'b0; tile2 = '0;
    v4 = 1'b0; tile4 = '0;
    tick();
    tick();
    check("rst_out", out2, 16'h0);
    check("rst_lv", lv2, 2'b00);
    check("rst_busy", busy2, 1'b0);
    check("rst_done", done2, 1'b0);
    check("rst_ready_low", r2, 1'b0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", r2, 1'b1);

    // idle hold
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_out", out2, 16'h0);
      check("idle_lv", lv2, 2'b00);
      check("idle_done", done2, 1'b0);
      check("idle_ready", r2, 1'b1);
    end

    // vector table
    for (int i = 0; i < 19; i++) begin
      v2 = vecs[i].in_valid;
      tile2 = vecs[i].a_tile;
      #1;
      check($sformatf("v%0d_ready", i), r2, vecs[i].exp_ready);
      tick();
      check($sformatf("v%0d_out", i), out2, vecs[i].exp_out);
      check($sformatf("v%0d_lv", i), lv2, vecs[i].exp_lv);
      check($sformatf("v%0d_busy", i), busy2, vecs[i].exp_busy);
      check($sformatf("v%0d_done", i), done2, vecs[i].exp_done);
    end

    // reset during step 1
    v2 = 1'b1; tile2 = TA;
    tick();
    v2 = 1'b0;
    tick();
    check("mid_step1_out", out2, 16'h0302);
    reset = 1'b1;
    #1;
    check("mid_rst_ready_low", r2, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_out", out2, 16'h0);
    check("mid_rst_lv", lv2, 2'b00);
    check("mid_rst_busy", busy2, 1'b0);
    check("mid_rst_done", done2, 1'b0);
    check("mid_rst_ready", r2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_done", done2, 1'b0);
      check("mid_rst_quiet", out2, 16'h0);
    end
    v2 = 1'b1; tile2 = TB;
    tick();
    v2 = 1'b0; tile2 = '0;
    check("fresh_s0", out2, 16'h0005);
    tick();
    check("fresh_s1", out2, 16'h0706);
    tick();
    check("fresh_s2", out2, 16'h0800);
    check("fresh_done", done2, 1'b1);
    tick();
    check("fresh_idle", busy2, 1'b0);

    // N=4, K=3, element [r][k] = r*10+k
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 3; k++) begin
        e8 = 8'(r*10 + k);
        tile4[(r*3+k)*8 +: 8] = e8;
      end
    v4 = 1'b1;
    #1;
    check("n4_ready", r4, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick();
      v4 = 1'b0;
      tile4 = '0;
      for (int r = 0; r < 4; r++) begin
        logic [7:0] ev;
        logic       vv;
        vv = (c - r >= 0) && (c - r < 3);
        ev = vv ? 8'(r*10 + c - r) : 8'h00;
        check($sformatf("n4_s%0d_l%0d", c, r), out4[r*8 +: 8], ev);
        check($sformatf("n4_s%0d_v%0d", c, r), lv4[r], vv);
      end
      check($sformatf("n4_s%0d_done", c), done4, (c == 5));
      check($sformatf("n4_s%0d_busy", c), busy4, 1'b1);
      if (c == 3) check("n4_s3_lv", lv4, 4'b1110);
      if (c == 5) check("n4_s5_lane3", out4[31:24], 8'd32);
    end
    tick();
    check("n4_idle_out", out4, 32'h0);
    check("n4_idle_busy", busy4, 1'b0);
    check("n4_idle_ready", r4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
